// File: rtl/timer_pkg.sv
// Shared state encoding and BCD digit limits for the countdown timer.
package timer_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUNNING = 2'd1;
   localparam logic [1:0] ST_PAUSED  = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   localparam logic [3:0] SECS_MAX = 4'd9;
   localparam logic [3:0] TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit that counts down, wrapping to MAX with a borrow; load beats dec.
module bcd_digit_down
   import timer_pkg::*;
#(
   parameter logic [3:0] MAX = SECS_MAX
) (
   input  logic       CLK,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic [3:0] value,
   output logic       borrow_out,
   output logic       is_zero
);

   assign is_zero    = (value == 4'd0);
   assign borrow_out = dec && is_zero;

   always_ff @(posedge CLK) begin
      if (clear) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (dec) begin
         value <= is_zero ? MAX : value - 4'd1;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Kitchen-style BCD countdown timer with keypad entry and start/stop buttons.
// Define TIMER_ADD30_EN to enable the +30 s button.
module countdown_timer
   import timer_pkg::*;
#(
   parameter int MIN_DIGITS = 2
) (
   input  logic                    CLK,
   input  logic                    clear,
   input  logic                    tick,
   input  logic [3:0]              digit,
   input  logic                    digit_valid,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    add30,
   output logic [4*MIN_DIGITS-1:0] minutes,
   output logic [3:0]              tens_secs,
   output logic [3:0]              secs,
   output logic                    running,
   output logic                    timer_done
);

   logic [1:0]              state;
   logic [1:0]              next_state;

   logic                    ld;
   logic [3:0]              ld_secs;
   logic [3:0]              ld_tens;
   logic [4*MIN_DIGITS-1:0] ld_min;
   logic                    dec_tick;

   logic                    secs_borrow;
   logic                    secs_zero;
   logic                    tens_zero;
   logic [MIN_DIGITS:0]     min_chain;
   logic [MIN_DIGITS-1:0]   min_zero_v;
   logic                    min_zero;
   logic                    time_zero;
   logic                    time_one;

   logic [4*MIN_DIGITS-1:0] min_inc;
   logic                    min_inc_ovf;
   logic [4*MIN_DIGITS-1:0] min_all9;
   logic                    unused_top_borrow;

   assign min_zero  = &min_zero_v;
   assign time_zero = min_zero && tens_zero && secs_zero;
   assign time_one  = min_zero && tens_zero && (secs == 4'd1);

   // Borrow out of the top minute digit would only fire on a tick at 0:00,
   // which the state machine never allows.
   assign unused_top_borrow = min_chain[MIN_DIGITS];

   always_comb begin
      min_inc     = minutes;
      min_inc_ovf = 1'b1;
      min_all9    = '0;
      for (int unsigned i = 0; i < MIN_DIGITS; i++) begin
         min_all9[4*i +: 4] = SECS_MAX;
         if (min_inc_ovf) begin
            if (minutes[4*i +: 4] == SECS_MAX) begin
               min_inc[4*i +: 4] = '0;
            end else begin
               min_inc[4*i +: 4] = minutes[4*i +: 4] + 4'd1;
               min_inc_ovf       = 1'b0;
            end
         end
      end
   end

   // Every non-tick change is expressed as a parallel load of all digits;
   // ticks use the borrow chain through the digit counters.
   always_comb begin
      next_state = state;
      ld         = 1'b0;
      ld_secs    = secs;
      ld_tens    = tens_secs;
      ld_min     = minutes;
      dec_tick   = 1'b0;

      if (stop && state == ST_RUNNING) begin
         next_state = ST_PAUSED;
      end else if (stop && (state == ST_PAUSED || state == ST_DONE)) begin
         ld         = 1'b1;
         ld_secs    = '0;
         ld_tens    = '0;
         ld_min     = '0;
         next_state = ST_IDLE;
      end else if (start && state == ST_IDLE && !time_zero) begin
         ld         = 1'b1;
         next_state = ST_RUNNING;
         if (tens_secs > TENS_MAX) begin
            if (min_inc_ovf) begin
               ld_tens = TENS_MAX;
               ld_secs = SECS_MAX;
            end else begin
               ld_tens = tens_secs - 4'd6;
               ld_min  = min_inc;
            end
         end
      end else if (start && state == ST_PAUSED) begin
         next_state = ST_RUNNING;
`ifdef TIMER_ADD30_EN
      end else if (add30 && (state == ST_IDLE || state == ST_DONE)) begin
         ld         = 1'b1;
         ld_secs    = '0;
         ld_tens    = 4'd3;
         ld_min     = '0;
         next_state = ST_RUNNING;
      end else if (add30 && (state == ST_RUNNING || state == ST_PAUSED)) begin
         ld = 1'b1;
         if (tens_secs >= 4'd3) begin
            if (min_inc_ovf) begin
               ld_min  = min_all9;
               ld_tens = TENS_MAX;
               ld_secs = SECS_MAX;
            end else begin
               ld_tens = tens_secs - 4'd3;
               ld_min  = min_inc;
            end
         end else begin
            ld_tens = tens_secs + 4'd3;
         end
`endif
      end else if (digit_valid && digit <= SECS_MAX &&
                   (state == ST_IDLE || state == ST_DONE)) begin
         ld         = 1'b1;
         next_state = ST_IDLE;
         ld_secs    = digit;
         if (state == ST_DONE) begin
            ld_tens = '0;
            ld_min  = '0;
         end else begin
            ld_tens = secs;
            for (int unsigned i = 1; i < MIN_DIGITS; i++) begin
               ld_min[4*i +: 4] = minutes[4*(i-1) +: 4];
            end
            ld_min[3:0] = tens_secs;
         end
      end else if (tick && state == ST_RUNNING) begin
         dec_tick = 1'b1;
         if (time_one) begin
            next_state = ST_DONE;
         end
      end
   end

`ifndef TIMER_ADD30_EN
   logic unused_add30;
   assign unused_add30 = add30;
`endif

   always_ff @(posedge CLK) begin
      if (clear) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   assign running    = (state == ST_RUNNING);
   assign timer_done = (state == ST_DONE);

   bcd_digit_down #(.MAX(SECS_MAX)) u_secs (
      .CLK        (CLK),
      .clear      (clear),
      .load       (ld),
      .load_val   (ld_secs),
      .dec        (dec_tick),
      .value      (secs),
      .borrow_out (secs_borrow),
      .is_zero    (secs_zero)
   );

   bcd_digit_down #(.MAX(TENS_MAX)) u_tens (
      .CLK        (CLK),
      .clear      (clear),
      .load       (ld),
      .load_val   (ld_tens),
      .dec        (secs_borrow),
      .value      (tens_secs),
      .borrow_out (min_chain[0]),
      .is_zero    (tens_zero)
   );

   for (genvar g = 0; g < MIN_DIGITS; g++) begin : g_min
      bcd_digit_down #(.MAX(SECS_MAX)) u_digit (
         .CLK        (CLK),
         .clear      (clear),
         .load       (ld),
         .load_val   (ld_min[4*g +: 4]),
         .dec        (min_chain[g]),
         .value      (minutes[4*g +: 4]),
         .borrow_out (min_chain[g+1]),
         .is_zero    (min_zero_v[g])
      );
   end

endmodule
